// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle for the RV32I execute stage.
// The master drives operands and opcode fields; the slave (alu_exec_unit)
// returns the registered result and decoded op.
// Optional macro ALU_ZERO_FLAG_EN adds a registered zero flag.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [6:0]       opcode;
    logic [2:0]       funct;
    logic             add_rshift_type;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [3:0]       ALUop;
    logic [WIDTH-1:0] Out;
`ifdef ALU_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output in_valid, opcode, funct, add_rshift_type, A, B,
        input  out_valid, ALUop, Out, zero
    );

    modport slave (
        input  in_valid, opcode, funct, add_rshift_type, A, B,
        output out_valid, ALUop, Out, zero
    );
`else
    modport master (
        output in_valid, opcode, funct, add_rshift_type, A, B,
        input  out_valid, ALUop, Out
    );

    modport slave (
        input  in_valid, opcode, funct, add_rshift_type, A, B,
        output out_valid, ALUop, Out
    );
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I integer execute stage: decodes opcode/funct3/bit30 into a 4-bit ALU
// operation, computes the result, and registers result and op with one
// cycle of latency and valid tracking. No stall or backpressure.
// Optional macro ALU_ZERO_FLAG_EN adds a registered zero flag on the bus.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    alu_exec_unit_if.slave bus
);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SLL    = 4'd2,
        OP_SLT    = 4'd3,
        OP_SLTU   = 4'd4,
        OP_XOR    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_OR     = 4'd8,
        OP_AND    = 4'd9,
        OP_COPY_B = 4'd10
    } alu_op_e;

    alu_op_e            dec_op;
    logic [WIDTH-1:0]   result;
    logic [SHAMT_W-1:0] shamt;

    logic             out_valid_d, out_valid_q;
    logic [3:0]       aluop_d, aluop_q;
    logic [WIDTH-1:0] out_d, out_q;

    // Decode: only the arithmetic opcodes look at funct3; bit30 selects
    // SUB only for R-type, and SRA for both R- and I-type.
    always_comb begin
        dec_op = OP_ADD;
        if (bus.opcode == OPC_LUI || bus.opcode == OPC_CSR) begin
            dec_op = OP_COPY_B;
        end else if (bus.opcode == OPC_ARI_RTYPE || bus.opcode == OPC_ARI_ITYPE) begin
            case (bus.funct)
                F3_ADD_SUB: dec_op = (bus.opcode == OPC_ARI_RTYPE && bus.add_rshift_type)
                                     ? OP_SUB : OP_ADD;
                F3_SLL:     dec_op = OP_SLL;
                F3_SLT:     dec_op = OP_SLT;
                F3_SLTU:    dec_op = OP_SLTU;
                F3_XOR:     dec_op = OP_XOR;
                F3_SRL_SRA: dec_op = bus.add_rshift_type ? OP_SRA : OP_SRL;
                F3_OR:      dec_op = OP_OR;
                F3_AND:     dec_op = OP_AND;
                default:    dec_op = OP_ADD;
            endcase
        end
    end

    assign shamt = bus.B[SHAMT_W-1:0];

    // Execute: shifts use only the low B bits; unused op codes yield zero.
    always_comb begin
        result = '0;
        case (dec_op)
            OP_ADD:    result = bus.A + bus.B;
            OP_SUB:    result = bus.A - bus.B;
            OP_SLL:    result = bus.A << shamt;
            OP_SLT:    result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU:   result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_XOR:    result = bus.A ^ bus.B;
            OP_SRL:    result = bus.A >> shamt;
            OP_SRA:    result = $signed(bus.A) >>> shamt;
            OP_OR:     result = bus.A | bus.B;
            OP_AND:    result = bus.A & bus.B;
            OP_COPY_B: result = bus.B;
            default:   result = '0;
        endcase
    end

    // Next-state for the pipeline register: capture on valid, otherwise hold
    // the data and drop valid.
    always_comb begin
        out_valid_d = bus.in_valid;
        aluop_d     = aluop_q;
        out_d       = out_q;
        if (bus.in_valid) begin
            aluop_d = dec_op;
            out_d   = result;
        end
    end

    // Pipeline register; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            aluop_q     <= 4'd0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            aluop_q     <= aluop_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ALUop     = aluop_q;
    assign bus.Out       = out_q;

`ifdef ALU_ZERO_FLAG_EN
    logic zero_d, zero_q;

    // Zero flag follows the captured result and holds with it.
    always_comb begin
        zero_d = zero_q;
        if (bus.in_valid) begin
            zero_d = (result == '0);
        end
    end

    // Zero flag register, cleared with the rest of the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed decode/execute cases,
// reset behaviour, boundaries, and a random back-to-back stream with a gap.
// Expected results are queued when driven and popped when the result appears.
module tb_alu_exec_unit;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ITYPE = 7'b0010011;
    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] CSR   = 7'b1110011;
    localparam logic [6:0] NOOP  = 7'b0000000;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  op;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];
    logic [31:0] hold_out;
    logic [3:0]  hold_op;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a broken DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference decode.
    function automatic logic [3:0] ref_op(input logic [6:0] opc, input logic [2:0] f, input logic b30);
        if (opc == LUI || opc == CSR) return 4'd10;
        if (opc != RTYPE && opc != ITYPE) return 4'd0;
        if (f == 3'b000) return (opc == RTYPE && b30) ? 4'd1 : 4'd0;
        if (f == 3'b101) return b30 ? 4'd7 : 4'd6;
        if (f == 3'b001) return 4'd2;
        if (f == 3'b010) return 4'd3;
        if (f == 3'b011) return 4'd4;
        if (f == 3'b100) return 4'd5;
        if (f == 3'b110) return 4'd8;
        return 4'd9;
    endfunction

    // Independent reference execute; SRA built by explicit sign fill.
    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] fill;
        sh = int'(b[4:0]);
        fill = (a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a << sh;
            4'd3:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd4:  return {31'd0, a < b};
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return (a >> sh) | fill;
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle of inputs at the falling edge; queue the expectation.
    task automatic apply_stimulus(input logic v, input logic [6:0] opc, input logic [2:0] f,
                                  input logic b30, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp_out, input logic [3:0] exp_op);
        exp_t e;
        @(negedge clk);
        bus.in_valid        = v;
        bus.opcode          = opc;
        bus.funct           = f;
        bus.add_rshift_type = b30;
        bus.A               = a;
        bus.B               = b;
        if (v) begin
            e.out = exp_out;
            e.op  = exp_op;
            sb.push_back(e);
        end
    endtask

    // Sample just after the capturing edge and compare with the scoreboard.
    task automatic check_output(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check_val({tag, "_out"}, bus.Out, e.out);
            check_val({tag, "_op"}, {28'd0, bus.ALUop}, {28'd0, e.op});
`ifdef ALU_ZERO_FLAG_EN
            check_val({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, e.out == 32'd0});
`endif
            hold_out = e.out;
            hold_op  = e.op;
        end else begin
            check_val({tag, "_gapvalid"}, {31'd0, bus.out_valid}, 32'd0);
            check_val({tag, "_gapout"}, bus.Out, hold_out);
            check_val({tag, "_gapop"}, {28'd0, bus.ALUop}, {28'd0, hold_op});
`ifdef ALU_ZERO_FLAG_EN
            check_val({tag, "_gapzero"}, {31'd0, bus.zero}, {31'd0, hold_out == 32'd0});
`endif
        end
    endtask

    task automatic run_vec(input string tag, input logic [6:0] opc, input logic [2:0] f,
                           input logic b30, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_out, input logic [3:0] exp_op);
        apply_stimulus(1'b1, opc, f, b30, a, b, exp_out, exp_op);
        check_output(tag);
    endtask

    initial begin
        logic [6:0] non_alu[7];
        logic [6:0] alu_opcs[4];
        logic [6:0] opc;
        logic [2:0] f;
        logic       b30;
        logic [31:0] a, b;
        logic [3:0] op;

        checks   = 0;
        failures = 0;
        hold_out = 32'd0;
        hold_op  = 4'd0;
        non_alu  = '{AUIPC, JAL, JALR, BR, LOAD, STORE, NOOP};
        alu_opcs = '{RTYPE, ITYPE, LUI, CSR};

        rst                 = 1'b1;
        bus.in_valid        = 1'b0;
        bus.opcode          = 7'd0;
        bus.funct           = 3'd0;
        bus.add_rshift_type = 1'b0;
        bus.A               = 32'd0;
        bus.B               = 32'd0;

        #1;
        check_val("rst_out", bus.Out, 32'd0);
        check_val("rst_op", {28'd0, bus.ALUop}, 32'd0);
        check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset and LUI");
        run_vec("lui", LUI, 3'd5, 1'b1, 32'h1234_5678, 32'hFFFF_8123, 32'hFFFF_8123, 4'd10);

        // Asynchronous reset mid-stream: a result in flight is discarded.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = RTYPE;
        bus.funct    = 3'b110;
        bus.A        = 32'hF0F0_0000;
        bus.B        = 32'h0000_0F0F;
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_out", bus.Out, 32'd0);
        check_val("arst_op", {28'd0, bus.ALUop}, 32'd0);
        check_val("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_val("arst_hold_out", bus.Out, 32'd0);
        check_val("arst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        hold_out = 32'd0;
        hold_op  = 4'd0;

        $display("[TB] non-ALU opcodes");
        foreach (non_alu[i]) begin
            run_vec($sformatf("nonalu%0d", i), non_alu[i], 3'($urandom_range(7)), 1'($urandom_range(1)),
                    32'h8000_0001, 32'hFFFF_8001, 32'h7FFF_8002, 4'd0);
        end
        run_vec("csr", CSR, 3'($urandom_range(7)), 1'($urandom_range(1)),
                32'h8000_0001, 32'hFFFF_8001, 32'hFFFF_8001, 4'd10);

        $display("[TB] R-type and I-type");
        run_vec("r_sub", RTYPE, 3'b000, 1'b1, 32'h8000_0010, 32'hFFFF_8003, 32'h8000_800D, 4'd1);
        run_vec("r_sra", RTYPE, 3'b101, 1'b1, 32'h8000_0010, 32'hFFFF_8003, 32'hF000_0002, 4'd7);
        run_vec("r_srl", RTYPE, 3'b101, 1'b0, 32'h8000_0010, 32'hFFFF_8003, 32'h1000_0002, 4'd6);
        run_vec("r_sll", RTYPE, 3'b001, 1'b1, 32'h8000_0010, 32'hFFFF_8003, 32'h0000_0080, 4'd2);
        run_vec("i_add", ITYPE, 3'b000, 1'b1, 32'd5, 32'd3, 32'd8, 4'd0);
        run_vec("i_srai", ITYPE, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 4'd7);
        run_vec("i_xor", ITYPE, 3'b100, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 4'd5);
        run_vec("r_and", RTYPE, 3'b111, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'd9);

        $display("[TB] boundaries");
        run_vec("slt_min", RTYPE, 3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 4'd3);
        run_vec("sltu_min", RTYPE, 3'b011, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 4'd4);
        run_vec("slt_neg", ITYPE, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 4'd3);
        run_vec("srl_sh0", RTYPE, 3'b101, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 4'd6);
        run_vec("sll_sh0", ITYPE, 3'b001, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 4'd2);
        run_vec("add_wrap", RTYPE, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd0);

        $display("[TB] random pipelined stream");
        fork
            begin
                for (int k = 0; k < 26; k++) begin
                    if (k == 12) begin
                        apply_stimulus(1'b0, RTYPE, 3'b000, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'd0, 4'd0);
                    end else begin
                        opc = (($urandom_range(3)) == 0) ? non_alu[$urandom_range(6)]
                                                         : alu_opcs[$urandom_range(3)];
                        f   = 3'($urandom_range(7));
                        b30 = 1'($urandom_range(1));
                        a   = $urandom;
                        b   = $urandom;
                        op  = ref_op(opc, f, b30);
                        apply_stimulus(1'b1, opc, f, b30, a, b, ref_res(op, a, b), op);
                    end
                end
            end
            begin
                for (int k = 0; k < 26; k++) begin
                    check_output($sformatf("rnd%0d", k));
                end
            end
        join
        @(negedge clk);
        bus.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- 32-bit RV32I integer execute stage: decodes opcode/funct3/funct7[5] into a 4-bit ALU operation and computes the result from operands A and B.
- Result and decoded op are registered: one-cycle latency with valid tracking.
- Sits between the operand muxes (A = rs1/PC, B = rs2/immediate) and the writeback/memory-address path.

Parameters:
- WIDTH, 32, datapath width; only 32 is required to be supported.
- SHAMT_W, 5, number of low B bits used as the shift amount.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode are valid this cycle.
- opcode  input  7  instruction opcode field [6:0].
- funct  input  3  instruction funct3 field.
- add_rshift_type  input  1  instruction bit 30 (funct7[5]).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  Out/ALUop are valid.
- ALUop  output  4  registered decoded operation.
- Out  output  WIDTH  registered result.

Behaviour:
- Opcodes:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011.
  - LOAD 0000011, STORE 0100011, ARI_ITYPE 0010011, ARI_RTYPE 0110011.
  - CSR 1110011, NOOP 0000000.
- funct3: ADD_SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL_SRA 101, OR 110, AND 111.
- ALUop encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, COPY_B 10; 11-15 unused.
- Decode (combinational):
  - LUI, CSR -> COPY_B.
  - AUIPC, JAL, JALR, BRANCH, LOAD, STORE, NOOP and any unlisted opcode -> ADD; funct and add_rshift_type are ignored.
  - ARI_RTYPE: funct3 selects the op. 000 gives SUB if add_rshift_type=1, else ADD. 101 gives SRA if add_rshift_type=1, else SRL. All other funct3 values ignore add_rshift_type.
  - ARI_ITYPE: same as ARI_RTYPE, except 000 is always ADD; add_rshift_type is honoured only for 101.
- Execute (combinational):
  - ADD = A+B and SUB = A-B, both modulo 2^32 with no flags.
  - SLL = A<<B[4:0]; SRL = logical A>>B[4:0]; SRA = arithmetic (sign-fill) A>>>B[4:0]. B[31:5] are ignored for shifts.
  - SLT = {31'b0, signed(A)<signed(B)}; SLTU = {31'b0, A<B}.
  - XOR/OR/AND are bitwise; COPY_B = B.
  - Unused ALUop codes produce 0.
- Pipeline register:
  - Rising edge with in_valid=1: Out<=result, ALUop<=decoded op, out_valid<=1.
  - Rising edge with in_valid=0: out_valid<=0; Out and ALUop hold their previous values.
  - Latency is exactly 1 cycle; back-to-back inputs give one result per cycle; there is no stall or backpressure.
- Reset: asserting Reset immediately (asynchronously) forces Out=0, ALUop=0 (ADD) and out_valid=0. This applies mid-stream too; an in-flight result is discarded. First capture occurs on the first rising edge after deassertion.
- Boundaries:
  - Shift by 0 returns A unchanged.
  - SRA with A[31]=1 and shift 31 returns 0xFFFFFFFF.
  - SLT with A=0x80000000, B=0x7FFFFFFF returns 1; SLTU with the same operands returns 0.
  - Overflow wraps silently.

Optional Feature:
- Macro ALU_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit), registered alongside Out.
  - zero=1 when the captured result equals 0; reset value 0; holds when in_valid=0.
- Not defined: port is absent; all other behaviour is identical.

Test Plan:
- Reset: assert Reset between edges -> Out=0, ALUop=0, out_valid=0 immediately. Deassert, then apply LUI with B=0xFFFF8123 -> next cycle Out=0xFFFF8123, ALUop=10, out_valid=1.
- Non-ALU opcodes with random funct/bit30:
  - AUIPC/JAL/JALR/BRANCH/LOAD/STORE/NOOP with A=0x80000001, B=0xFFFF8001 -> Out=0x7FFF8002, ALUop=0.
  - CSR with the same operands -> Out=B.
- R-type, A=0x80000010, B=0xFFFF8003:
  - funct 000, bit30=1 -> Out=0x8000800D (SUB).
  - funct 101, bit30=1 -> 0xF0000002.
  - funct 101, bit30=0 -> 0x10000002.
  - funct 001 -> 0x00000080.
- I-type funct 000 with bit30=1 -> ADD, not SUB: A=5, B=3 -> Out=8.
- Compares:
  - A=0x80000000, B=0x7FFFFFFF: SLT -> 1, SLTU -> 0.
  - A=0xFFFFFFFF, B=0xFFFFFFFE: SLT -> 0.
- Pipelining: 25 back-to-back random vectors, with in_valid dropped one cycle mid-stream.
  - Each Out matches its reference exactly one cycle later.
  - out_valid is 0 and Out holds during the gap.
